// File: rtl/word_stream_arb.sv
// Round-robin word-stream arbiter: grants one source at a time for bursts of up to BURST_LEN words.
// Define WORD_STREAM_ARB_HDR_EN to emit a channel header word before each burst.
module word_stream_arb #(
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_SRC*WORD_BITS-1:0] i_data,
    input  logic [N_SRC-1:0]           i_valid,
    output logic [N_SRC-1:0]           o_ready,
    output logic [WORD_BITS-1:0]       o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [2:0]                 o_chan
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
`ifdef WORD_STREAM_ARB_HDR_EN
    localparam logic [1:0] S_HDR  = 2'd2;
`endif

    logic [1:0]           state, state_nxt;
    logic [IDX_W-1:0]     grant, grant_nxt;
    logic [IDX_W-1:0]     last, last_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;

    logic                 found;
    logic [IDX_W-1:0]     pick;
    logic [WORD_BITS-1:0] src_word;
    logic                 src_valid;

    // Cyclic search starting at last+1: indices above last first, then wrap from 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < int'(N_SRC); k++) begin
            if (!found && i_valid[k] && (IDX_W'(k) > last)) begin
                found = 1'b1;
                pick  = IDX_W'(k);
            end
        end
        for (int k = 0; k < int'(N_SRC); k++) begin
            if (!found && i_valid[k] && (IDX_W'(k) <= last)) begin
                found = 1'b1;
                pick  = IDX_W'(k);
            end
        end
    end

    // Mux the granted source's word and valid.
    always_comb begin
        src_word  = '0;
        src_valid = 1'b0;
        for (int k = 0; k < int'(N_SRC); k++) begin
            if (grant == IDX_W'(k)) begin
                src_word  = i_data[k*WORD_BITS +: WORD_BITS];
                src_valid = i_valid[k];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            grant <= '0;
            last  <= IDX_W'(N_SRC - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and output decode; outputs are forced idle while reset is high.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        cnt_nxt   = cnt;
        o_valid   = 1'b0;
        o_ready   = '0;
        o_data    = '0;
        o_chan    = '0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (found) begin
                    grant_nxt = pick;
`ifdef WORD_STREAM_ARB_HDR_EN
                    state_nxt = S_HDR;
`else
                    state_nxt = S_XFER;
                    last_nxt  = pick;
`endif
                end
            end
`ifdef WORD_STREAM_ARB_HDR_EN
            S_HDR: begin
                o_valid = 1'b1;
                o_data  = {{(WORD_BITS-8){1'b1}}, 5'b0, grant};
                o_chan  = grant;
                if (i_ready) begin
                    state_nxt = S_XFER;
                    last_nxt  = grant;
                end
            end
`endif
            S_XFER: begin
                o_data  = src_word;
                o_valid = src_valid;
                o_chan  = grant;
                for (int k = 0; k < int'(N_SRC); k++) begin
                    o_ready[k] = (grant == IDX_W'(k)) && i_ready;
                end
                if (!src_valid) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (i_ready) begin
                    if (cnt == CNT_W'(BURST_LEN - 1)) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (i_rst) begin
            o_valid = 1'b0;
            o_ready = '0;
            o_chan  = '0;
        end
    end

endmodule

// File: tb/tb_word_stream_arb.sv
// Directed self-checking bench for word_stream_arb (WORD_BITS=32, N_SRC=4, BURST_LEN=4).
// Builds with WORD_STREAM_ARB_HDR_EN defined run the header scenario instead.
module tb_word_stream_arb;

    logic         i_clk;
    logic         i_rst;
    logic [127:0] i_data;
    logic [3:0]   i_valid;
    logic [3:0]   o_ready;
    logic [31:0]  o_data;
    logic         o_valid;
    logic         i_ready;
    logic [2:0]   o_chan;

    logic [31:0]  d [4];
    int           checks;
    int           errors;

    assign i_data = {d[3], d[2], d[1], d[0]};

    word_stream_arb #(
        .WORD_BITS(32),
        .N_SRC(4),
        .BURST_LEN(4)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_chan (o_chan)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic out(input string tag, input logic ev, input logic [31:0] ed,
                       input logic [3:0] er, input logic [2:0] ec);
        chk({tag, ".valid"}, 64'(o_valid), 64'(ev));
        if (ev) chk({tag, ".data"}, 64'(o_data), 64'(ed));
        chk({tag, ".ready"}, 64'(o_ready), 64'(er));
        chk({tag, ".chan"}, 64'(o_chan), 64'(ec));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        i_rst   = 1'b1;
        i_ready = 1'b1;
        i_valid = 4'hF;
        for (int k = 0; k < 4; k++) d[k] = 32'hC0DE_0000 + 32'(k);

        repeat (2) @(negedge i_clk);
        #1 out("reset", 1'b0, 32'h0, 4'b0000, 3'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

`ifndef WORD_STREAM_ARB_HDR_EN
        // All sources valid: bursts of 4 with one idle cycle, rotating 0,1,2,3,0.
        for (int r = 0; r < 5; r++) begin
            #1 out("s1_idle", 1'b0, 32'h0, 4'b0000, 3'd0);
            for (int w = 0; w < 4; w++) begin
                @(negedge i_clk);
                #1 out("s1_xfer", 1'b1, d[r % 4], 4'(1 << (r % 4)), 3'(r % 4));
            end
            @(negedge i_clk);
        end

        // Only src2 valid, incrementing data.
        i_valid = 4'b0100;
        d[2]    = 32'hAABB_CCDD;
        #1 out("s2_idle0", 1'b0, 32'h0, 4'b0000, 3'd0);
        @(negedge i_clk);
        #1 out("s2_w0", 1'b1, 32'hAABB_CCDD, 4'b0100, 3'd2);
        @(negedge i_clk); d[2] = d[2] + 32'd1;
        #1 out("s2_w1", 1'b1, 32'hAABB_CCDE, 4'b0100, 3'd2);
        @(negedge i_clk); d[2] = d[2] + 32'd1;
        #1 out("s2_w2", 1'b1, 32'hAABB_CCDF, 4'b0100, 3'd2);
        @(negedge i_clk); d[2] = d[2] + 32'd1;
        #1 out("s2_w3", 1'b1, 32'hAABB_CCE0, 4'b0100, 3'd2);
        @(negedge i_clk); d[2] = d[2] + 32'd1;
        #1 out("s2_idle1", 1'b0, 32'h0, 4'b0000, 3'd0);
        @(negedge i_clk);
        #1 out("s2_w4", 1'b1, 32'hAABB_CCE1, 4'b0100, 3'd2);
        @(negedge i_clk); d[2] = d[2] + 32'd1; i_valid = 4'b0000;
        #1 out("s2_release", 1'b0, 32'h0, 4'b0100, 3'd2);

        // src1 burst stalled by i_ready low for 10 cycles after two words.
        @(negedge i_clk);
        i_valid = 4'b0010;
        d[1]    = 32'h1111_0000;
        #1 out("s3_idle", 1'b0, 32'h0, 4'b0000, 3'd0);
        @(negedge i_clk);
        #1 out("s3_w0", 1'b1, 32'h1111_0000, 4'b0010, 3'd1);
        @(negedge i_clk); d[1] = d[1] + 32'd1;
        #1 out("s3_w1", 1'b1, 32'h1111_0001, 4'b0010, 3'd1);
        @(negedge i_clk); d[1] = d[1] + 32'd1; i_ready = 1'b0;
        #1 out("s3_stall", 1'b1, 32'h1111_0002, 4'b0000, 3'd1);
        repeat (9) begin
            @(negedge i_clk);
            #1 out("s3_stall", 1'b1, 32'h1111_0002, 4'b0000, 3'd1);
        end
        @(negedge i_clk); i_ready = 1'b1;
        #1 out("s3_w2", 1'b1, 32'h1111_0002, 4'b0010, 3'd1);
        @(negedge i_clk); d[1] = d[1] + 32'd1;
        #1 out("s3_w3", 1'b1, 32'h1111_0003, 4'b0010, 3'd1);
        @(negedge i_clk); d[1] = d[1] + 32'd1; i_valid = 4'b0000;
        #1 out("s3_done", 1'b0, 32'h0, 4'b0000, 3'd0);

        // src0 drops valid after two words; src3 waiting gets the next grant.
        @(negedge i_clk);
        i_valid = 4'b0001;
        d[0]    = 32'h0000_00A0;
        #1 out("s4_idle0", 1'b0, 32'h0, 4'b0000, 3'd0);
        @(negedge i_clk);
        i_valid = 4'b1001;
        d[3]    = 32'h0000_00D3;
        #1 out("s4_w0", 1'b1, 32'h0000_00A0, 4'b0001, 3'd0);
        @(negedge i_clk); d[0] = 32'h0000_00A1;
        #1 out("s4_w1", 1'b1, 32'h0000_00A1, 4'b0001, 3'd0);
        @(negedge i_clk); d[0] = 32'h0000_00A2; i_valid = 4'b1000;
        #1 out("s4_drop", 1'b0, 32'h0, 4'b0001, 3'd0);
        @(negedge i_clk);
        #1 out("s4_idle1", 1'b0, 32'h0, 4'b0000, 3'd0);
        for (int w = 0; w < 4; w++) begin
            @(negedge i_clk);
            #1 out("s4_src3", 1'b1, 32'h0000_00D3, 4'b1000, 3'd3);
        end
        @(negedge i_clk); i_valid = 4'b0000;
        #1 out("s4_done", 1'b0, 32'h0, 4'b0000, 3'd0);

        // Reset pulse during word 2 of a src1 burst.
        @(negedge i_clk);
        i_valid = 4'b0010;
        d[1]    = 32'h0000_5550;
        #1 out("s5_idle0", 1'b0, 32'h0, 4'b0000, 3'd0);
        @(negedge i_clk);
        #1 out("s5_w0", 1'b1, 32'h0000_5550, 4'b0010, 3'd1);
        @(negedge i_clk); d[1] = 32'h0000_5551; i_rst = 1'b1;
        #1 out("s5_rst", 1'b0, 32'h0, 4'b0000, 3'd0);
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_valid = 4'b0011;
        d[0]    = 32'h0000_6660;
        #1 out("s5_idle1", 1'b0, 32'h0, 4'b0000, 3'd0);
        @(negedge i_clk);
        #1 out("s5_regrant", 1'b1, 32'h0000_6660, 4'b0001, 3'd0);
        @(negedge i_clk); i_valid = 4'b0000;
        #1 out("s5_release", 1'b0, 32'h0, 4'b0001, 3'd0);
        @(negedge i_clk);
        #1 out("s5_idle2", 1'b0, 32'h0, 4'b0000, 3'd0);
`else
        // Header for src2, stalled for 3 cycles, then 4 data words.
        i_valid = 4'b0100;
        d[2]    = 32'h2222_0000;
        #1 out("h_idle0", 1'b0, 32'h0, 4'b0000, 3'd0);
        @(negedge i_clk); i_ready = 1'b0;
        #1 out("h_stall", 1'b1, 32'hFFFF_FF02, 4'b0000, 3'd2);
        repeat (2) begin
            @(negedge i_clk);
            #1 out("h_stall", 1'b1, 32'hFFFF_FF02, 4'b0000, 3'd2);
        end
        @(negedge i_clk); i_ready = 1'b1;
        #1 out("h_hdr", 1'b1, 32'hFFFF_FF02, 4'b0000, 3'd2);
        for (int w = 0; w < 4; w++) begin
            @(negedge i_clk);
            #1 out("h_data", 1'b1, 32'h2222_0000, 4'b0100, 3'd2);
        end
        @(negedge i_clk); i_valid = 4'b0000;
        #1 out("h_idle1", 1'b0, 32'h0, 4'b0000, 3'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
